muldiv_ctrl: RTL
================

// Module: muldiv_ctrl
// PURPOSE
//  Sequencer for the EX-stage multiply/divide resources. Accepts one mult/multu/div/divu op
//  from EX, drives the pipelined multiplier and the iterative divider, holds the pipeline
//  via stallreq until the result exists, then emits a single HI/LO write toward MEM.
//  Handles divide-by-zero without the divider and cancels in-flight work on flush.
// PARAMETERS
//  MUL_LAT  2   multiplier latency in cycles from operands valid to mul_result valid (1..15)
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  rst          in   1   synchronous reset, active-high
//  op_valid     in   1   EX holds a mul/div op; stays high while stalled
//  op           in   2   00 mult, 01 multu, 10 div, 11 divu
//  src_a        in   32  rs operand (dividend / multiplicand)
//  src_b        in   32  rt operand (divisor / multiplier)
//  flush        in   1   cancel current op, no HI/LO write
//  mul_signed   out  1   to multiplier: signed product
//  mul_ina      out  32  to multiplier operand A (latched)
//  mul_inb      out  32  to multiplier operand B (latched)
//  mul_result   in   64  product {hi,lo}
//  div_start    out  1   to divider: start/hold request
//  div_signed   out  1   to divider: signed divide
//  div_opdata1  out  32  dividend (latched)
//  div_opdata2  out  32  divisor (latched)
//  div_annul    out  1   to divider: abort current division
//  div_ready    in   1   divider result valid (single-cycle pulse)
//  div_result   in   64  {remainder, quotient}
//  stallreq     out  1   hold IF..EX
//  busy         out  1   state != IDLE
//  hilo_we      out  1   write HI and LO this cycle
//  hi_wdata     out  32  HI value
//  lo_wdata     out  32  LO value
// BEHAVIOUR
//  Reset: state IDLE, operand latches and hi/lo regs 0, cnt 0; every output 0.
//  States: IDLE, MUL, DIV, DONE. stallreq = (IDLE & op_valid & ~flush) | MUL | DIV.
//  IDLE: on op_valid & ~flush latch src_a/src_b/op. op[1]=0 -> MUL, cnt=MUL_LAT-1.
//    op[1]=1 & src_b==0 -> DONE with hi=src_a, lo=32'hFFFF_FFFF (divider not started).
//    op[1]=1 & src_b!=0 -> DIV.
//  MUL: mul_* driven from latches, mul_signed=~op[0]. cnt==0 -> capture hi=mul_result[63:32],
//    lo=mul_result[31:0], -> DONE; else cnt-1. Total stall = MUL_LAT+1 cycles.
//  DIV: div_start=1, div_signed=~op[0], opdata from latches, until div_ready sampled 1;
//    then div_start=0 same cycle, capture hi=div_result[63:32], lo=div_result[31:0], -> DONE.
//  DONE: hilo_we=1, hi/lo_wdata = captured regs, stallreq=0 (EX advances); -> IDLE.
//    op_valid is ignored in DONE (same instruction); the next op is accepted earliest next cycle.
//  hi/lo_wdata are 0 whenever hilo_we=0.
//  flush in any state: -> IDLE next cycle, stallreq=0 that cycle, no hilo_we; if in DIV,
//    div_annul=1 for that one cycle and div_start=0. flush beats op_valid and div_ready.
//  Reset mid-operation: abandon op, no write; divider is reset by the same rst.
//  op_valid dropping while MUL/DIV (not via flush) is a protocol error; op continues.
// TESTING
//  mult src_a=-3 src_b=5, MUL_LAT=2 -> stallreq 3 cycles, then hilo_we=1 hi=FFFFFFFF lo=FFFFFFF1.
//  multu src_a=FFFFFFFF src_b=2 -> hi=00000001 lo=FFFFFFFE, one hilo_we pulse only.
//  div src_a=-7 src_b=2, ready after 33 cycles -> div_start high 33 cycles, hi=FFFFFFFF lo=FFFFFFFD.
//  divu src_b=0 src_a=1234 -> no div_start, stall 1 cycle, hi=00001234 lo=FFFFFFFF.
//  flush at DIV cycle 10 -> div_annul 1 cycle, stallreq drops, no hilo_we; next divu completes.
//  rst asserted in MUL -> next cycle all outputs 0, busy 0; back-to-back mult/div each write once.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide sequencer: latches one op, drives the multiplier or divider,
// stalls the pipe until the result exists, then issues a single HI/LO write.
module muldiv_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_opdata1,
  output logic [31:0] div_opdata2,
  output logic        div_annul,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        stallreq,
  output logic        busy,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        uns_q, uns_d;   // op[0]: unsigned variant
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      uns_q   <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      uns_q   <= uns_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    uns_d   = uns_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (op_valid) begin
          a_d   = src_a;
          b_d   = src_b;
          uns_d = op[0];
          if (!op[1]) begin
            state_d = S_MUL;
            cnt_d   = CNT_INIT;
          end else if (src_b == 32'd0) begin
            // divide-by-zero resolves here without ever starting the divider
            state_d = S_DONE;
            hi_d    = src_a;
            lo_d    = 32'hFFFF_FFFF;
          end else begin
            state_d = S_DIV;
          end
        end
        S_MUL: if (cnt_q == 4'd0) begin
          hi_d    = mul_result[63:32];
          lo_d    = mul_result[31:0];
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
        S_DIV: if (div_ready) begin
          hi_d    = div_result[63:32];
          lo_d    = div_result[31:0];
          state_d = S_DONE;
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    mul_signed  = 1'b0;
    mul_ina     = a_q;
    mul_inb     = b_q;
    div_start   = 1'b0;
    div_signed  = 1'b0;
    div_opdata1 = a_q;
    div_opdata2 = b_q;
    div_annul   = 1'b0;
    stallreq    = 1'b0;
    busy        = (state_q != S_IDLE);
    hilo_we     = 1'b0;
    hi_wdata    = '0;
    lo_wdata    = '0;
    unique case (state_q)
      S_IDLE: stallreq = op_valid & ~flush;
      S_MUL: begin
        mul_signed = ~uns_q;
        stallreq   = ~flush;
      end
      S_DIV: begin
        div_signed = ~uns_q;
        div_start  = ~div_ready & ~flush;
        div_annul  = flush;
        stallreq   = ~flush;
      end
      S_DONE: if (!flush) begin
        hilo_we  = 1'b1;
        hi_wdata = hi_q;
        lo_wdata = lo_q;
      end
      default: ;
    endcase
  end

endmodule
